// File: rtl/crc16_rx_chk.sv
// crc16_rx_chk: receive-side USB DATA-phase stage.
// Forwards PID (optional) and payload bytes from the PHY byte stream to the
// link layer with valid/ready on both sides. The two trailing CRC16 bytes are
// withheld, EOP is moved onto the last payload byte, and CRC status plus the
// payload length are reported at packet end.
// Optional feature macro: CRC16_RX_LEN_CHK_EN (drop payload beyond MAX_LEN, flag len_err).
module crc16_rx_chk #(
    parameter int MAX_LEN  = 1024,
    parameter int PID_PASS = 1,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_data_on,
    input  logic             rx_sop,
    input  logic             rx_eop,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [7:0]       rx_data,
    output logic             rx_lt_sop,
    output logic             rx_lt_eop,
    output logic             rx_lt_valid,
    input  logic             rx_lt_ready,
    output logic [7:0]       rx_lt_data,
    output logic             rx_sop_en,
    output logic             rx_lt_eop_en,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic [LEN_W-1:0] rx_len
);

    typedef enum logic {IDLE, PKT} state_t;

    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [15:0]      CRC_POLY = 16'hA001;
    localparam logic [15:0]      CRC_GOOD = 16'hB001;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    // Reflected CRC16 over one byte, bits taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int unsigned k = 0; k < 8; k++) begin
            c = (c >> 1) ^ ((c[0] ^ d[k]) ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    state_t           state_q, state_d;

    // Two-entry hold queue; slot 0 is the oldest. Only slot 0 can hold the PID.
    logic [7:0]       q0_data, q1_data;
    logic             q0_pid;
    logic [1:0]       q_cnt;

    logic             o_valid, o_sop, o_eop;
    logic [7:0]       o_data;

    logic [15:0]      crc_q, crc_nxt;
    logic [LEN_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       nafter_q, nafter_nxt;
    logic             first_q;

    logic             ok_q, err_q;
    logic [LEN_W-1:0] len_q;

    logic             q_full, acc, sop_acc, byte_acc, eop_acc, abort;
    logic             rel, rel_pay, rel_load, cnt_inc, short_pkt, len_bad, pkt_good;

`ifdef CRC16_RX_LEN_CHK_EN
    logic             ovf_q, ovf_nxt, rel_drop, len_err_q;
`endif

    assign q_full    = (q_cnt == 2'd2);
    assign rx_ready  = ~rx_data_on | ~q_full | ~o_valid | rx_lt_ready;
    assign acc       = rx_data_on & rx_valid & rx_ready;
    assign sop_acc   = acc & rx_sop;
    assign byte_acc  = acc & ~rx_sop & (state_q == PKT);
    assign eop_acc   = byte_acc & rx_eop;
    assign abort     = (state_q == PKT) & ~rx_data_on;

    // A byte entering a full queue pushes the oldest one out to the link.
    assign rel       = byte_acc & q_full;
    assign rel_pay   = rel & ~q0_pid;
    assign cnt_inc   = rel_pay & (cnt_q != LEN_MAX);
    assign cnt_nxt   = cnt_q + LEN_W'(cnt_inc);
    assign crc_nxt   = crc16_byte(crc_q, rx_data);
    assign nafter_nxt = (nafter_q == 2'd2) ? 2'd2 : nafter_q + 2'd1;
    assign short_pkt = (nafter_nxt != 2'd2);

`ifdef CRC16_RX_LEN_CHK_EN
    assign rel_drop  = rel_pay & (cnt_q == LEN_MAX);
    assign rel_load  = rel & ~rel_drop;
    assign ovf_nxt   = ovf_q | rel_drop;
    assign len_bad   = ovf_nxt;
    assign len_err   = len_err_q;
`else
    assign rel_load  = rel;
    assign len_bad   = 1'b0;
    assign len_err   = 1'b0;
`endif

    assign pkt_good  = ~short_pkt & ~len_bad & (crc_nxt == CRC_GOOD);

    assign rx_lt_valid  = o_valid;
    assign rx_lt_sop    = o_sop;
    assign rx_lt_eop    = o_eop;
    assign rx_lt_data   = o_data;
    assign rx_sop_en    = sop_acc;
    assign rx_lt_eop_en = o_valid & rx_lt_ready & o_eop;
    assign crc_ok       = ok_q;
    assign crc_err      = err_q;
    assign rx_len       = len_q;

    // Packet state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: enter on SOP, leave on EOP or when the DATA phase ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (sop_acc && !rx_eop) state_d = PKT;
            PKT: begin
                if (abort)        state_d = IDLE;
                else if (sop_acc) state_d = rx_eop ? IDLE : PKT;
                else if (eop_acc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold queue, CRC, length count and end-of-packet status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_data   <= '0;
            q1_data   <= '0;
            q0_pid    <= 1'b0;
            q_cnt     <= '0;
            crc_q     <= CRC_INIT;
            cnt_q     <= '0;
            nafter_q  <= '0;
            first_q   <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
`ifdef CRC16_RX_LEN_CHK_EN
            ovf_q     <= 1'b0;
            len_err_q <= 1'b0;
`endif
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
`ifdef CRC16_RX_LEN_CHK_EN
            len_err_q <= 1'b0;
`endif
            if (abort) q_cnt <= '0;

            if (sop_acc) begin
                crc_q    <= CRC_INIT;
                cnt_q    <= '0;
                nafter_q <= '0;
                first_q  <= 1'b1;
`ifdef CRC16_RX_LEN_CHK_EN
                ovf_q    <= 1'b0;
`endif
                if (PID_PASS != 0 && !rx_eop) begin
                    q0_data <= rx_data;
                    q0_pid  <= 1'b1;
                    q_cnt   <= 2'd1;
                end else begin
                    q_cnt   <= '0;
                end
                // A PID that is also the last byte is a short packet.
                if (rx_eop) begin
                    err_q <= 1'b1;
                    len_q <= '0;
                end
            end else if (byte_acc) begin
                crc_q    <= crc_nxt;
                nafter_q <= nafter_nxt;
                cnt_q    <= cnt_nxt;
`ifdef CRC16_RX_LEN_CHK_EN
                ovf_q    <= ovf_nxt;
`endif
                if (rel) first_q <= 1'b0;
                if (rx_eop) begin
                    // Remaining queue content is the CRC (or a short-packet residue).
                    q_cnt <= '0;
                    ok_q  <= pkt_good;
                    err_q <= ~pkt_good;
                    len_q <= cnt_nxt;
`ifdef CRC16_RX_LEN_CHK_EN
                    len_err_q <= len_bad;
`endif
                end else if (q_full) begin
                    q0_data <= q1_data;
                    q0_pid  <= 1'b0;
                    q1_data <= rx_data;
                end else if (q_cnt == 2'd0) begin
                    q0_data <= rx_data;
                    q0_pid  <= 1'b0;
                    q_cnt   <= 2'd1;
                end else begin
                    q1_data <= rx_data;
                    q_cnt   <= 2'd2;
                end
            end
        end
    end

    // Link output register: loaded on release, held while stalled, drains on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_data  <= '0;
        end else if (rel_load) begin
            o_valid <= 1'b1;
            o_sop   <= first_q;
            o_eop   <= rx_eop;
            o_data  <= q0_data;
        end else if (o_valid && rx_lt_ready) begin
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc16_rx_chk.sv
// Directed bench for crc16_rx_chk: one instance with PID_PASS=1 and one with
// PID_PASS=0, both MAX_LEN=4. Expected beats and status are built in the bench.
module tb_crc16_rx_chk;

    localparam int MAXL = 4;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          on1 = 1'b0, on0 = 1'b0;
    logic          sop = 1'b0, eop = 1'b0, valid = 1'b0, lt_ready = 1'b1;
    logic [7:0]    data = '0;
    logic          tgt0 = 1'b0;

    logic          rdy1, lsop1, leop1, lval1, sopen1, lteopen1, ok1, err1, lerr1;
    logic [7:0]    ldat1;
    logic [LW-1:0] len1;
    logic          rdy0, lsop0, leop0, lval0, sopen0, lteopen0, ok0, err0, lerr0;
    logic [7:0]    ldat0;
    logic [LW-1:0] len0;

    always #5 clk = ~clk;

    crc16_rx_chk #(.MAX_LEN(MAXL), .PID_PASS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_data_on(on1), .rx_sop(sop), .rx_eop(eop),
        .rx_valid(valid), .rx_ready(rdy1), .rx_data(data),
        .rx_lt_sop(lsop1), .rx_lt_eop(leop1), .rx_lt_valid(lval1), .rx_lt_ready(lt_ready),
        .rx_lt_data(ldat1), .rx_sop_en(sopen1), .rx_lt_eop_en(lteopen1),
        .crc_ok(ok1), .crc_err(err1), .len_err(lerr1), .rx_len(len1)
    );

    crc16_rx_chk #(.MAX_LEN(MAXL), .PID_PASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data_on(on0), .rx_sop(sop), .rx_eop(eop),
        .rx_valid(valid), .rx_ready(rdy0), .rx_data(data),
        .rx_lt_sop(lsop0), .rx_lt_eop(leop0), .rx_lt_valid(lval0), .rx_lt_ready(lt_ready),
        .rx_lt_data(ldat0), .rx_sop_en(sopen0), .rx_lt_eop_en(lteopen0),
        .crc_ok(ok0), .crc_err(err0), .len_err(lerr0), .rx_len(len0)
    );

    // Monitor: handshakes and pulses sampled on the falling edge.
    logic [9:0]    beats1[$], beats0[$];
    int unsigned   nok1 = 0, nerr1 = 0, nlerr1 = 0, nsopen1 = 0, nlteop1 = 0;
    int unsigned   nok0 = 0, nerr0 = 0, nlerr0 = 0;
    logic [LW-1:0] lastlen1 = '0, lastlen0 = '0;

    always @(negedge clk) begin
        if (lval1 && lt_ready) beats1.push_back({lsop1, leop1, ldat1});
        if (lval0 && lt_ready) beats0.push_back({lsop0, leop0, ldat0});
        if (ok1)  nok1++;
        if (err1) nerr1++;
        if (lerr1) nlerr1++;
        if (ok1 || err1) lastlen1 = len1;
        if (sopen1) nsopen1++;
        if (lteopen1) nlteop1++;
        if (ok0)  nok0++;
        if (err0) nerr0++;
        if (lerr0) nlerr0++;
        if (ok0 || err0) lastlen0 = len0;
    end

    int unsigned checks = 0, failures = 0;
    int unsigned b_ok, b_err, b_lerr, b_beats, b_sopen, b_lteop;
    logic [7:0]  pay[$];
    logic [9:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] crc16_of();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (pay[i]) begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (c[0] ^ pay[i][k]) c = (c >> 1) ^ 16'hA001;
                else                  c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int unsigned waited;
        waited = 0;
        data = d; sop = s; eop = e; valid = 1'b1;
        @(negedge clk);
        while (!(tgt0 ? rdy0 : rdy1) && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        chk("accept_wait", 32'(waited < 50), 32'd1);
        @(posedge clk); #1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] crc_xor);
        logic [15:0] c;
        c = crc16_of();
        send_byte(8'hC3, 1'b1, 1'b0);
        foreach (pay[i]) send_byte(pay[i], 1'b0, 1'b0);
        send_byte(c[7:0] ^ crc_xor, 1'b0, 1'b0);
        send_byte(c[15:8], 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_ok    = tgt0 ? nok0 : nok1;
        b_err   = tgt0 ? nerr0 : nerr1;
        b_lerr  = tgt0 ? nlerr0 : nlerr1;
        b_beats = tgt0 ? beats0.size() : beats1.size();
        b_sopen = nsopen1;
        b_lteop = nlteop1;
    endtask

    task automatic exp_build(input bit with_pid, input int unsigned nfwd, input bit last_eop);
        exp_q.delete();
        if (with_pid) exp_q.push_back({1'b1, (nfwd == 0) & last_eop, 8'hC3});
        for (int unsigned i = 0; i < nfwd; i++)
            exp_q.push_back({(!with_pid) && (i == 0), last_eop && (i == nfwd - 1), pay[i]});
    endtask

    task automatic chk_beats(input string tag);
        int unsigned got;
        got = (tgt0 ? beats0.size() : beats1.size()) - b_beats;
        chk({tag, "_nbeats"}, got, exp_q.size());
        for (int unsigned i = 0; i < exp_q.size() && i < got; i++)
            chk({tag, "_beat"}, 32'(tgt0 ? beats0[b_beats + i] : beats1[b_beats + i]), 32'(exp_q[i]));
    endtask

    task automatic chk_status(input string tag, input int unsigned e_ok, input int unsigned e_err,
                              input int unsigned e_lerr, input int unsigned e_len);
        chk({tag, "_ok"},   (tgt0 ? nok0 : nok1) - b_ok, e_ok);
        chk({tag, "_err"},  (tgt0 ? nerr0 : nerr1) - b_err, e_err);
        chk({tag, "_lerr"}, (tgt0 ? nlerr0 : nlerr1) - b_lerr, e_lerr);
        chk({tag, "_len"},  32'(tgt0 ? lastlen0 : lastlen1), e_len);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut1", 32'({rdy1, lsop1, leop1, lval1, ldat1, sopen1, lteopen1, ok1, err1, lerr1, len1}),
            32'h80000);
        chk("reset_dut0", 32'({rdy0, lsop0, leop0, lval0, ldat0, sopen0, lteopen0, ok0, err0, lerr0, len0}),
            32'h80000);
        rst_n = 1'b1;
        on1   = 1'b1;
        @(posedge clk); #1;

        // Basic packet, payload length equal to MAX_LEN.
        pay = '{8'h00, 8'h01, 8'h02, 8'h03};
        snap();
        send_pkt(8'h00);
        exp_build(1'b1, 4, 1'b1);
        chk_beats("t1");
        chk_status("t1", 1, 0, 0, 4);
        chk("t1_sop_en", nsopen1 - b_sopen, 1);
        chk("t1_lt_eop_en", nlteop1 - b_lteop, 1);

        // Corrupted CRC low byte: same beats, error status.
        snap();
        send_pkt(8'h01);
        chk_beats("t2");
        chk_status("t2", 0, 1, 0, 4);

        // Short packet: PID plus one byte.
        snap();
        send_byte(8'hC3, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        exp_q.delete();
        chk_beats("short");
        chk_status("short", 0, 1, 0, 0);

        // Zero-length packet, PID forwarded with sop and eop.
        pay.delete();
        snap();
        send_pkt(8'h00);
        exp_build(1'b1, 0, 1'b1);
        chk_beats("t3a");
        chk_status("t3a", 1, 0, 0, 0);

        // PID_PASS=0 instance: zero-length then 4-byte packet.
        on1 = 1'b0; on0 = 1'b1; tgt0 = 1'b1;
        @(posedge clk); #1;
        snap();
        send_pkt(8'h00);
        exp_q.delete();
        chk_beats("t3b");
        chk_status("t3b", 1, 0, 0, 0);
        pay = '{8'h00, 8'h01, 8'h02, 8'h03};
        snap();
        send_pkt(8'h00);
        exp_build(1'b0, 4, 1'b1);
        chk_beats("t3c");
        chk_status("t3c", 1, 0, 0, 4);
        on0 = 1'b0; on1 = 1'b1; tgt0 = 1'b0;
        @(posedge clk); #1;

        // Link stall: PID waits in the output register while the queue is full.
        snap();
        begin
            logic [15:0] c;
            c = crc16_of();
            lt_ready = 1'b0;
            send_byte(8'hC3, 1'b1, 1'b0);
            send_byte(8'h00, 1'b0, 1'b0);
            send_byte(8'h01, 1'b0, 1'b0);
            data = 8'h02; valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("t4_stall", 32'({rdy1, lval1, lsop1, ldat1}), 32'({1'b0, 1'b1, 1'b1, 8'hC3}));
            end
            @(posedge clk); #1;
            lt_ready = 1'b1;
            send_byte(8'h02, 1'b0, 1'b0);
            send_byte(8'h03, 1'b0, 1'b0);
            send_byte(c[7:0], 1'b0, 1'b0);
            send_byte(c[15:8], 1'b0, 1'b1);
            repeat (4) @(posedge clk);
            #1;
        end
        exp_build(1'b1, 4, 1'b1);
        chk_beats("t4");
        chk_status("t4", 1, 0, 0, 4);

        // Abort via rx_data_on after 3 payload bytes, then a clean packet.
        snap();
        send_byte(8'hC3, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        on1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        on1 = 1'b1;
        send_pkt(8'h00);
        exp_build(1'b1, 4, 1'b1);
        exp_q.push_front({2'b00, 8'h00});
        exp_q.push_front({2'b10, 8'hC3});
        chk_beats("t5");
        chk_status("t5", 1, 0, 0, 4);

        // Payload of 6 bytes against MAX_LEN=4.
        pay = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        snap();
        send_pkt(8'h00);
`ifdef CRC16_RX_LEN_CHK_EN
        exp_build(1'b1, 4, 1'b0);
        chk_beats("t6");
        chk_status("t6", 0, 1, 1, 4);
`else
        exp_build(1'b1, 6, 1'b1);
        chk_beats("t6");
        chk_status("t6", 1, 0, 0, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
